// File: rtl/register_file_sb_pkg.sv
// Shared constants and address-width helper for the register file with scoreboard.
package register_file_sb_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Write, read, issue and scoreboard-status signals of the register file.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int AW = addr_width(DEPTH);

    logic             LD;
    logic [AW-1:0]    DR;
    logic [WIDTH-1:0] D_IN;
    logic [AW-1:0]    SA;
    logic [AW-1:0]    SB;
    logic [WIDTH-1:0] DATA_A;
    logic [WIDTH-1:0] DATA_B;
    logic             ISSUE;
    logic [AW-1:0]    ISSUE_DR;
    logic             READY_A;
    logic             READY_B;
    logic [AW:0]      PEND_CNT;

    modport master (
        output LD, DR, D_IN, SA, SB, ISSUE, ISSUE_DR,
        input  DATA_A, DATA_B, READY_A, READY_B, PEND_CNT
    );

    modport slave (
        input  LD, DR, D_IN, SA, SB, ISSUE, ISSUE_DR,
        output DATA_A, DATA_B, READY_A, READY_B, PEND_CNT
    );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-result scoreboard: one bit per register, population count and operand-ready flags.
module reg_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      issue_i,
    input  logic [addr_width(DEPTH)-1:0] issue_dr_i,
    input  logic                      ld_i,
    input  logic [addr_width(DEPTH)-1:0] dr_i,
    input  logic [addr_width(DEPTH)-1:0] sa_i,
    input  logic [addr_width(DEPTH)-1:0] sb_i,
    output logic                      ready_a_o,
    output logic                      ready_b_o,
    output logic [addr_width(DEPTH):0] pend_cnt_o
);
    localparam int AW = addr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [CW-1:0]    pend_cnt_q;
    logic [CW-1:0]    pend_cnt_d;

    // Clear before set so a same-cycle issue to the written register leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (ld_i) begin
            pending_d[dr_i] = 1'b0;
        end
        if (issue_i) begin
            pending_d[issue_dr_i] = 1'b1;
        end
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(pending_d[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign ready_a_o  = !pending_q[sa_i] || (BYPASS && ld_i && (dr_i == sa_i));
    assign ready_b_o  = !pending_q[sb_i] || (BYPASS && ld_i && (dr_i == sb_i));
    assign pend_cnt_o = pend_cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with write-to-read bypass and a result scoreboard.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    register_file_sb_if.slave bus
);
    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             wr_en;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             ready_a;
    logic             ready_b;
    logic [AW:0]      pend_cnt;

    assign wr_en = bus.LD && !(ZERO_REG && (bus.DR == '0));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.DR] <= bus.D_IN;
        end
    end

    // Address 0 reads zero even when a write to it is presented on the bus.
    always_comb begin
        data_a = regs_q[bus.SA];
        if (BYPASS && wr_en && (bus.DR == bus.SA)) begin
            data_a = bus.D_IN;
        end
        if (ZERO_REG && (bus.SA == '0)) begin
            data_a = '0;
        end
    end

    always_comb begin
        data_b = regs_q[bus.SB];
        if (BYPASS && wr_en && (bus.DR == bus.SB)) begin
            data_b = bus.D_IN;
        end
        if (ZERO_REG && (bus.SB == '0)) begin
            data_b = '0;
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .issue_i    (bus.ISSUE),
        .issue_dr_i (bus.ISSUE_DR),
        .ld_i       (bus.LD),
        .dr_i       (bus.DR),
        .sa_i       (bus.SA),
        .sb_i       (bus.SB),
        .ready_a_o  (ready_a),
        .ready_b_o  (ready_b),
        .pend_cnt_o (pend_cnt)
    );

    assign bus.DATA_A   = data_a;
    assign bus.DATA_B   = data_b;
    assign bus.READY_A  = ready_a;
    assign bus.READY_B  = ready_b;
    assign bus.PEND_CNT = pend_cnt;

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of registers; SHALL be a power of two >=2; AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the read ports.
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 LD  input  1  write enable.
REQ-008 DR  input  AW  write address.
REQ-009 D_IN  input  WIDTH  write data.
REQ-010 SA, SB  input  AW each  read addresses, ports A and B.
REQ-011 DATA_A, DATA_B  output  WIDTH each  read data.
REQ-012 ISSUE  input  1  marks register ISSUE_DR as pending (result outstanding).
REQ-013 ISSUE_DR  input  AW  register to mark pending.
REQ-014 READY_A, READY_B  output  1 each  operand at SA/SB is valid this cycle.
REQ-015 PEND_CNT  output  AW+1  number of registers currently pending.

Function
REQ-016 Reads SHALL be combinational: DATA_A = reg[SA], DATA_B = reg[SB], zero latency.
REQ-017 On rising CLK with LD=1, reg[DR] SHALL take D_IN; visible on DATA_x in the following cycle (or same cycle via bypass).
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0 regardless of bypass.
REQ-019 With BYPASS=1, LD=1 and DR==SA (not a zeroed address), DATA_A SHALL equal D_IN in the same cycle; likewise port B; with BYPASS=0 reads return stored value.
REQ-020 Scoreboard: one pending bit per register, cleared at reset.
REQ-021 On rising CLK, ISSUE=1 SHALL set pending[ISSUE_DR]; LD=1 SHALL clear pending[DR].
REQ-022 ISSUE and LD to the same address in the same cycle: pending SHALL end set (new issue wins).
REQ-023 ISSUE to an already-pending register SHALL leave it pending, PEND_CNT unchanged.
REQ-024 LD to a non-pending register SHALL write data and leave PEND_CNT unchanged.
REQ-025 With ZERO_REG=1, ISSUE to address 0 SHALL be ignored; register 0 is never pending.
REQ-026 READY_A = !pending[SA] OR (BYPASS=1 AND LD=1 AND DR==SA); same for B.
REQ-027 PEND_CNT SHALL equal the population count of pending bits after every edge; +1, -1 or 0 per cycle per REQ-021..025; never exceeds DEPTH (or DEPTH-1 with ZERO_REG=1).

Reset
REQ-028 RST_N low SHALL immediately, independent of CLK, clear all registers to 0, all pending bits to 0, PEND_CNT to 0; hence DATA_x=0 (absent bypass), READY_x=1.
REQ-029 Writes/issues coinciding with active reset SHALL be discarded; operation resumes on the first rising CLK after RST_N deasserts.

Structure
REQ-030 A shared package SHALL hold default WIDTH/DEPTH constants and the AW derivation helper used by the datapath.
REQ-031 The scoreboard (pending bits, PEND_CNT, READY logic) SHALL be one sub-module, reg_scoreboard; storage and bypass stay in the top.

Verification
REQ-032 Reset then write: RST_N low, release, LD=1 DR=3 D_IN=123 one edge, SA=3 -> DATA_A=123, READY_A=1.
REQ-033 Bypass: LD=1 DR=5 D_IN=0xDEADBEEF, SA=5, SB=5 same cycle -> DATA_A=DATA_B=0xDEADBEEF before edge; with BYPASS=0 -> old value 0.
REQ-034 Zero register: LD=1 DR=0 D_IN=77, ISSUE DR=0 -> DATA_A(SA=0)=0, READY_A=1, PEND_CNT=0.
REQ-035 Scoreboard: ISSUE 2, then ISSUE 4 -> PEND_CNT=2, READY(SA=2)=0; LD DR=2 -> PEND_CNT=1, READY=1; same-cycle ISSUE 4 + LD 4 -> register 4 stays pending, PEND_CNT=1.
REQ-036 Async reset mid-operation: with 3 pending and data written, pull RST_N low between edges -> all DATA_x=0, PEND_CNT=0 immediately, no wait for CLK.
REQ-037 Parameter sweep: WIDTH=16/DEPTH=4 and WIDTH=64/DEPTH=32 pass REQ-032..036 with all addresses exercised.
